// File: rtl/ddr3_app_driver.sv
// rtl/ddr3_app_driver.sv - request sequencer between a valid/ready request port and the MIG app interface
// One-entry hold register feeds the MIG ports; read credits bound a first-word fall-through response FIFO.
module ddr3_app_driver #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 512,
  parameter int RD_DEPTH = 8
) (
  input  logic                ui_clk,
  input  logic                sys_rst,
  input  logic                init_calib_complete,

  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_data,
  input  logic [DATA_W/8-1:0] req_mask,

  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,

  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,

  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,

  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  input  logic                rsp_ready,

  output logic                busy
);

  localparam int CW = $clog2(RD_DEPTH + 1);
  localparam int PW = $clog2(RD_DEPTH);
  localparam logic [CW-1:0] CRED_MAX = CW'(RD_DEPTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [2:0]    CMD_WR   = 3'b000;
  localparam logic [2:0]    CMD_RD   = 3'b001;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t state, state_nxt;

  logic                hold_valid;
  logic                hold_write;
  logic [ADDR_W-1:0]   hold_addr;
  logic [DATA_W-1:0]   hold_data;
  logic [DATA_W/8-1:0] hold_mask;
  logic                cmd_done;
  logic                wdf_done;

  logic [CW-1:0]       credits;
  logic                cmd_hs;
  logic                wdf_hs;
  logic                req_done;
  logic                accept;
  logic                rd_issue;
  logic                rsp_pop;

  logic [DATA_W-1:0]   fifo_mem [RD_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  logic                fifo_full;
  logic                fifo_push;

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_INIT;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    case (state)
      ST_INIT: begin
        if (init_calib_complete) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        req_ready = !hold_valid || req_done;
        if (!init_calib_complete) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  // Command and write data are independent handshakes; each output drops once its own side is done.
  assign app_en       = hold_valid && !cmd_done && (hold_write || credits != '0);
  assign app_wdf_wren = hold_valid && hold_write && !wdf_done;
  assign app_wdf_end  = app_wdf_wren;
  assign app_addr     = hold_addr;
  assign app_cmd      = hold_write ? CMD_WR : CMD_RD;
  assign app_wdf_data = hold_data;
  assign app_wdf_mask = hold_mask;

  assign cmd_hs   = app_en && app_rdy;
  assign wdf_hs   = app_wdf_wren && app_wdf_rdy;
  assign req_done = hold_valid &&
                    (hold_write ? ((cmd_done || cmd_hs) && (wdf_done || wdf_hs)) : cmd_hs);
  assign accept   = req_valid && req_ready;
  assign rd_issue = cmd_hs && !hold_write;
  assign rsp_pop  = rsp_valid && rsp_ready;

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hold_valid <= 1'b0;
      cmd_done   <= 1'b0;
      wdf_done   <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      cmd_done   <= 1'b0;
      wdf_done   <= 1'b0;
    end else if (req_done) begin
      hold_valid <= 1'b0;
      cmd_done   <= 1'b0;
      wdf_done   <= 1'b0;
    end else begin
      if (cmd_hs) cmd_done <= 1'b1;
      if (wdf_hs) wdf_done <= 1'b1;
    end
  end

  // Payload fields carry no reset: they are only observed while hold_valid is set.
  always_ff @(posedge ui_clk) begin
    if (accept) begin
      hold_write <= req_write;
      hold_addr  <= req_addr;
      hold_data  <= req_data;
      hold_mask  <= req_mask;
    end
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      credits <= CRED_MAX;
    end else if (rd_issue && !rsp_pop) begin
      credits <= credits - CNT_ONE;
    end else if (!rd_issue && rsp_pop && credits != CRED_MAX) begin
      credits <= credits + CNT_ONE;
    end
  end

  // app_rd_data cannot be stalled, so every issued read already owns a FIFO slot.
  assign fifo_full = (fifo_cnt == CRED_MAX);
  assign fifo_push = app_rd_data_valid && (!fifo_full || rsp_pop);
  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_data  = fifo_mem[rd_ptr];

  always_ff @(posedge ui_clk) begin
    if (fifo_push) fifo_mem[wr_ptr] <= app_rd_data;
  end

  always_ff @(posedge ui_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      assert (!(app_rd_data_valid && fifo_full));
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (rsp_pop)   rd_ptr <= rd_ptr + PTR_ONE;
      if (fifo_push && !rsp_pop)      fifo_cnt <= fifo_cnt + CNT_ONE;
      else if (!fifo_push && rsp_pop) fifo_cnt <= fifo_cnt - CNT_ONE;
    end
  end

  assign busy = hold_valid || (credits != CRED_MAX);

endmodule

// File: tb/tb_ddr3_app_driver.sv
// tb/tb_ddr3_app_driver.sv - self-checking bench for ddr3_app_driver
// Directed table and corner sequences, then randomized traffic against a queue-based reference model.
module tb_ddr3_app_driver;

  localparam int AW = 28;
  localparam int DW = 64;
  localparam int MW = DW / 8;
  localparam int DEPTH = 4;

  logic          ui_clk;
  logic          sys_rst;
  logic          init_calib_complete;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  logic [MW-1:0] req_mask;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data;
  logic [MW-1:0] app_wdf_mask;
  logic          app_wdf_wren;
  logic          app_wdf_end;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          rsp_ready;
  logic          busy;

  ddr3_app_driver #(.ADDR_W(AW), .DATA_W(DW), .RD_DEPTH(DEPTH)) dut (
    .ui_clk(ui_clk), .sys_rst(sys_rst), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_wren(app_wdf_wren),
    .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready), .busy(busy)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  function automatic logic [63:0] rdata(input logic [AW-1:0] a);
    return {a ^ 28'h5A5A5A5, 8'hC3, a};
  endfunction

  function automatic logic [63:0] pat(input int i);
    return {32'hA5A50000 + 32'(i), 32'h12345678 ^ 32'(i)};
  endfunction

  typedef struct packed {
    logic calib, valid, rdy, wrdy;
    logic e_ready, e_en, e_wren, e_busy;
  } vec_t;

  typedef struct packed { logic w; logic [AW-1:0] a; } cmd_t;
  typedef struct packed { logic [DW-1:0] d; logic [MW-1:0] m; } wdf_t;

  localparam logic [63:0] TBL_DATA = 64'hDEAD_BEEF_0123_4567;

  initial begin
    vec_t          tbl [14];
    logic [AW-1:0] rd_addrs [$];
    logic [DW-1:0] got [$];
    cmd_t          cmd_q [$];
    wdf_t          wdf_q [$];
    logic [DW-1:0] exp_rsp [$];
    logic [DW-1:0] ret_d [$];
    int            ret_due [$];
    int n_acc, n_hs, hs5, first_pop, first_w, last_w, n_wdf, n_cmd, bad_d, bad_end, en_bad;
    int outstanding, fifo_cnt, last_due;
    bit d4_sent, pend;

    //           calib valid rdy wrdy | ready en wren busy
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    sys_rst = 1'b1; init_calib_complete = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
    app_rdy = 1'b0; app_wdf_rdy = 1'b0; app_rd_data = '0; app_rd_data_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_app_en", 64'(app_en), 64'(0));
    chk("rst_wren", 64'(app_wdf_wren), 64'(0));
    chk("rst_wdf_end", 64'(app_wdf_end), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    sys_rst = 1'b0;

    // Calibration gating, split command/write-data handshakes, calibration drop with a held write.
    for (int i = 0; i < 14; i++) begin
      tick();
      init_calib_complete = tbl[i].calib;
      req_valid = tbl[i].valid; req_write = 1'b1; req_addr = 28'h100;
      req_data = TBL_DATA; req_mask = 8'h0F;
      app_rdy = tbl[i].rdy; app_wdf_rdy = tbl[i].wrdy;
      #1;
      chk($sformatf("tbl%0d_req_ready", i), 64'(req_ready), 64'(tbl[i].e_ready));
      chk($sformatf("tbl%0d_app_en", i), 64'(app_en), 64'(tbl[i].e_en));
      chk($sformatf("tbl%0d_wren", i), 64'(app_wdf_wren), 64'(tbl[i].e_wren));
      chk($sformatf("tbl%0d_wdf_end", i), 64'(app_wdf_end), 64'(tbl[i].e_wren));
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_en) begin
        chk($sformatf("tbl%0d_addr", i), 64'(app_addr), 64'(28'h100));
        chk($sformatf("tbl%0d_cmd", i), 64'(app_cmd), 64'(3'b000));
      end
      if (tbl[i].e_wren) begin
        chk($sformatf("tbl%0d_wdata", i), app_wdf_data, TBL_DATA);
        chk($sformatf("tbl%0d_wmask", i), 64'(app_wdf_mask), 64'(8'h0F));
      end
    end

    // Credit exhaustion: five reads, no returned data.
    n_acc = 0; n_hs = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      req_valid = (n_acc < 5); req_write = 1'b0; req_addr = 28'(32'h200 + n_acc);
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; rsp_ready = 1'b0;
      #1;
      if (app_en && app_rdy) begin
        rd_addrs.push_back(app_addr);
        n_hs++;
        chk("rd_cmd_code", 64'(app_cmd), 64'(3'b001));
      end
      if (req_valid && req_ready) n_acc++;
    end
    chk("rd_accepted", 64'(n_acc), 64'(5));
    chk("rd_cmd_handshakes", 64'(n_hs), 64'(4));
    chk("rd_stall_app_en", 64'(app_en), 64'(0));
    chk("rd_stall_busy", 64'(busy), 64'(1));

    en_bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 1'b0;
      app_rd_data_valid = 1'b1; app_rd_data = rdata(rd_addrs[i]);
      #1;
      if (app_en) en_bad++;
    end
    tick();
    app_rd_data_valid = 1'b0;
    #1;
    chk("rd_stall_during_return", 64'(en_bad), 64'(0));
    chk("rsp_valid_after_return", 64'(rsp_valid), 64'(1));

    // Drain with rsp_ready toggling; the stalled fifth read issues the cycle after the first pop.
    hs5 = -1; first_pop = -1; d4_sent = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      rsp_ready = (c % 2 == 0);
      app_rd_data_valid = 1'b0;
      if (hs5 >= 0 && !d4_sent) begin
        app_rd_data_valid = 1'b1; app_rd_data = rdata(rd_addrs[4]); d4_sent = 1;
      end
      #1;
      if (rsp_valid && rsp_ready) begin
        got.push_back(rsp_data);
        if (first_pop < 0) first_pop = c;
      end
      if (app_en && app_rdy) begin
        rd_addrs.push_back(app_addr);
        hs5 = c;
      end
    end
    chk("rd5_issue_cycle", 64'(hs5), 64'(first_pop + 1));
    chk("rsp_count", 64'(got.size()), 64'(5));
    if (rd_addrs.size() == 5) chk("rd5_addr", 64'(rd_addrs[4]), 64'(28'h204));
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("rsp_order%0d", i), got[i], rdata(28'(32'h200 + i)));
    chk("rd_final_busy", 64'(busy), 64'(0));
    chk("rd_final_rsp_valid", 64'(rsp_valid), 64'(0));

    // Eight back-to-back writes with both MIG ports always ready.
    n_acc = 0; n_wdf = 0; n_cmd = 0; first_w = -1; last_w = -1; bad_d = 0; bad_end = 0;
    for (int c = 0; c < 16; c++) begin
      tick();
      req_valid = (n_acc < 8); req_write = 1'b1; req_addr = 28'(32'h300 + n_acc);
      req_data = pat(n_acc); req_mask = 8'(n_acc);
      app_rdy = 1'b1; app_wdf_rdy = 1'b1; rsp_ready = 1'b0;
      #1;
      if (app_wdf_wren && app_wdf_rdy) begin
        if (app_wdf_data !== pat(n_wdf) || app_wdf_mask !== 8'(n_wdf)) bad_d++;
        if (first_w < 0) first_w = c;
        last_w = c;
        n_wdf++;
      end
      if (app_en && app_rdy) n_cmd++;
      if (app_wdf_end !== app_wdf_wren) bad_end++;
      if (req_valid && req_ready) n_acc++;
    end
    chk("wr_wdf_handshakes", 64'(n_wdf), 64'(8));
    chk("wr_cmd_handshakes", 64'(n_cmd), 64'(8));
    chk("wr_consecutive", 64'(last_w - first_w), 64'(7));
    chk("wr_data_order", 64'(bad_d), 64'(0));
    chk("wr_end_eq_wren", 64'(bad_end), 64'(0));

    // Asynchronous reset with a write held and two reads outstanding.
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = 28'h400; app_rdy = 1'b1; app_wdf_rdy = 1'b0;
    tick();
    req_addr = 28'h401;
    tick();
    req_write = 1'b1; req_addr = 28'h402; req_data = pat(99);
    tick();
    req_valid = 1'b0; app_rdy = 1'b0;
    app_rd_data_valid = 1'b1; app_rd_data = rdata(28'h400);
    tick();
    app_rd_data_valid = 1'b0;
    #1;
    chk("pre_rst_app_en", 64'(app_en), 64'(1));
    chk("pre_rst_wren", 64'(app_wdf_wren), 64'(1));
    chk("pre_rst_rsp_valid", 64'(rsp_valid), 64'(1));
    chk("pre_rst_busy", 64'(busy), 64'(1));
    #1;
    sys_rst = 1'b1;
    #1;
    chk("async_rst_app_en", 64'(app_en), 64'(0));
    chk("async_rst_wren", 64'(app_wdf_wren), 64'(0));
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_req_ready", 64'(req_ready), 64'(0));
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'(0));

    // Randomized traffic against a request-level model with a MIG responder of random read latency.
    outstanding = 0; fifo_cnt = 0; last_due = 0; pend = 0;
    for (int c = 0; c < 3200; c++) begin
      logic exp_en, exp_wren, exp_ready, c_hs, w_hs, pop;
      int due;
      tick();
      if (c < 3000) begin
        if (!pend) begin
          req_valid = ($urandom_range(0, 9) < 7);
          req_write = 1'($urandom_range(0, 1));
          req_addr = 28'($urandom);
          req_data = {$urandom, $urandom};
          req_mask = 8'($urandom);
        end
        app_rdy = ($urandom_range(0, 3) != 0);
        app_wdf_rdy = ($urandom_range(0, 3) != 0);
        rsp_ready = ($urandom_range(0, 4) < 3);
      end else begin
        req_valid = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1; rsp_ready = 1'b1;
      end
      app_rd_data_valid = 1'b0;
      if (ret_d.size() > 0 && ret_due[0] <= c) begin
        app_rd_data_valid = 1'b1; app_rd_data = ret_d[0];
      end
      #1;
      exp_en = (cmd_q.size() > 0) && (cmd_q[0].w || outstanding < DEPTH);
      exp_wren = (wdf_q.size() > 0);
      c_hs = exp_en && app_rdy;
      w_hs = exp_wren && app_wdf_rdy;
      exp_ready = ((cmd_q.size() - int'(c_hs)) == 0) && ((wdf_q.size() - int'(w_hs)) == 0);
      chk("rnd_app_en", 64'(app_en), 64'(exp_en));
      chk("rnd_wren", 64'(app_wdf_wren), 64'(exp_wren));
      chk("rnd_wdf_end", 64'(app_wdf_end), 64'(exp_wren));
      chk("rnd_req_ready", 64'(req_ready), 64'(exp_ready));
      chk("rnd_busy", 64'(busy), 64'(cmd_q.size() > 0 || wdf_q.size() > 0 || outstanding != 0));
      chk("rnd_rsp_valid", 64'(rsp_valid), 64'(fifo_cnt > 0));
      if (exp_en) begin
        chk("rnd_app_addr", 64'(app_addr), 64'(cmd_q[0].a));
        chk("rnd_app_cmd", 64'(app_cmd), cmd_q[0].w ? 64'(0) : 64'(1));
      end
      if (exp_wren) begin
        chk("rnd_wdf_data", app_wdf_data, wdf_q[0].d);
        chk("rnd_wdf_mask", 64'(app_wdf_mask), 64'(wdf_q[0].m));
      end
      pop = (fifo_cnt > 0) && rsp_ready;
      if (pop) begin
        chk("rnd_rsp_data", rsp_data, exp_rsp[0]);
        void'(exp_rsp.pop_front());
        fifo_cnt--;
        outstanding--;
      end
      if (app_rd_data_valid) begin
        void'(ret_d.pop_front());
        void'(ret_due.pop_front());
        fifo_cnt++;
      end
      if (c_hs) begin
        cmd_t cc;
        cc = cmd_q.pop_front();
        if (!cc.w) begin
          outstanding++;
          due = c + 1 + int'($urandom_range(0, 4));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          ret_d.push_back(rdata(cc.a));
          ret_due.push_back(due);
        end
      end
      if (w_hs) void'(wdf_q.pop_front());
      pend = req_valid && !exp_ready;
      if (req_valid && exp_ready) begin
        cmd_q.push_back('{req_write, req_addr});
        if (req_write) wdf_q.push_back('{req_data, req_mask});
        else           exp_rsp.push_back(rdata(req_addr));
      end
    end
    chk("rnd_final_busy", 64'(busy), 64'(0));
    chk("rnd_final_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rnd_final_pending_rsp", 64'(exp_rsp.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
